// File: rtl/udec_bi.sv
// udec_bi: bipolar stochastic bitstream decoder.
// Counts the ones in a window of N = 2^BITWIDTH samples and reports
// ones - N/2 as a signed BITWIDTH+1 bit value.
// Optional macro UDEC_BI_CONTINUOUS_EN: windows run back-to-back and each
// result is flagged by a one-cycle oValid pulse. There is no handshake in
// that mode.
module udec_bi #(
  parameter int BITWIDTH = 8
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iEn,
  input  logic                       iClr,
  input  logic                       iStart,
  input  logic                       iBit,
  input  logic                       iAck,
  output logic                       oBusy,
  output logic                       oValid,
  output logic signed [BITWIDTH:0]   oValue
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  // Offset that turns the ones count into a bipolar value.
  localparam logic [BITWIDTH:0] HALF = (BITWIDTH+1)'(1) << (BITWIDTH-1);

  state_t                     state, stateNxt;
  logic [BITWIDTH:0]          ones;     // max value N, so one extra bit
  logic [BITWIDTH-1:0]        sampCnt;  // wraps N-1 -> 0 at window end
  logic                       validQ;
  logic signed [BITWIDTH:0]   valueQ;
  logic                       lastSample;
  logic [BITWIDTH:0]          onesNxt;

  assign lastSample = (state == ACC) && (sampCnt == '1);
  assign onesNxt    = ones + {{BITWIDTH{1'b0}}, iBit};

  // State register; clear wins over every other request.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)          state <= IDLE;
    else if (iEn) begin
      if (iClr)        state <= IDLE;
      else             state <= stateNxt;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: if (iStart) stateNxt = ACC;
      ACC: begin
        if (lastSample) begin
`ifdef UDEC_BI_CONTINUOUS_EN
          stateNxt = ACC;
`else
          stateNxt = DONE;
`endif
        end
      end
      DONE: if (iAck) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Counters and the registered result. All of them freeze while iEn is low.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      ones    <= '0;
      sampCnt <= '0;
      validQ  <= 1'b0;
      valueQ  <= '0;
    end else if (iEn) begin
      if (iClr) begin
        ones    <= '0;
        sampCnt <= '0;
        validQ  <= 1'b0;
        valueQ  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (iStart) begin
              ones    <= '0;
              sampCnt <= '0;
            end
          end
          ACC: begin
            sampCnt <= sampCnt + 1'b1;
            if (lastSample) begin
              // The final sample is folded in before the offset is removed.
              valueQ <= $signed(onesNxt - HALF);
              validQ <= 1'b1;
`ifdef UDEC_BI_CONTINUOUS_EN
              ones   <= '0;
`else
              ones   <= onesNxt;
`endif
            end else begin
              ones   <= onesNxt;
              validQ <= 1'b0;
            end
          end
          DONE: if (iAck) validQ <= 1'b0;
          default: validQ <= 1'b0;
        endcase
      end
    end
  end

  // Output decode.
  always_comb begin
    oBusy  = (state == ACC);
    oValid = validQ;
    oValue = valueQ;
  end

endmodule

// File: tb/tb_udec_bi.sv
// Directed bench for udec_bi with BITWIDTH=4 (N=16, offset 8).
module tb_udec_bi;
  localparam int BW = 4;

  logic iClk = 1'b0;
  logic iRst, iEn, iClr, iStart, iBit, iAck;
  logic oBusy, oValid;
  logic signed [BW:0] oValue;

  int checks = 0;
  int errors = 0;

  udec_bi #(.BITWIDTH(BW)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .iStart(iStart),
    .iBit(iBit), .iAck(iAck), .oBusy(oBusy), .oValid(oValid), .oValue(oValue)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  typedef struct {
    logic [15:0]        bits;     // bit i is the i-th sample
    int                 stallAt;  // sample index before which iEn drops (-1 none)
    int                 stallLen;
    logic signed [BW:0] expVal;
    int                 expLat;   // edges from iStart accept to oValid
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cyc;
    int pulses;
    int firstAt;
    int lastAt;
    bit sawValid;

    vecs[0] = '{16'hFFFF, -1, 0,  5'sd8,  17};
    vecs[1] = '{16'h0000, -1, 0, -5'sd8,  17};
    vecs[2] = '{16'h5555, -1, 0,  5'sd0,  17};
    vecs[3] = '{16'h0FFF, -1, 0,  5'sd4,  17};
    vecs[4] = '{16'h0FFF,  8, 5,  5'sd4,  22};
    vecs[5] = '{16'h0001, -1, 0, -5'sd7,  17};
    vecs[6] = '{16'h007F,  3, 2, -5'sd1,  19};

    iRst = 1'b1; iEn = 1'b0; iClr = 1'b0; iStart = 1'b0; iBit = 1'b0; iAck = 1'b0;
    #12;
    chk("rst_busy",  oBusy,  0);
    chk("rst_valid", oValid, 0);
    chk("rst_value", oValue, 0);
    @(negedge iClk);
    iRst = 1'b0; iEn = 1'b1;
    tick();

`ifdef UDEC_BI_CONTINUOUS_EN
    iStart = 1'b1;
    tick();
    iStart = 1'b0; iBit = 1'b1; iAck = 1'b1;
    pulses = 0; firstAt = -1; lastAt = -1;
    for (int n = 1; n <= 48; n++) begin
      tick();
      if (oValid) begin
        pulses++;
        if (firstAt < 0) firstAt = n;
        else chk("cont_spacing", n - lastAt, 16);
        lastAt = n;
        chk("cont_value", oValue, 8);
      end
      chk("cont_busy", oBusy, 1);
    end
    chk("cont_pulses", pulses, 3);
    chk("cont_first", firstAt, 16);
`else
    foreach (vecs[v]) begin
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      cyc = 1;
      chk($sformatf("v%0d_busy_start", v), oBusy, 1);
      for (int i = 0; i < 16; i++) begin
        if (i == vecs[v].stallAt) begin
          iEn = 1'b0;
          for (int s = 0; s < vecs[v].stallLen; s++) begin
            tick();
            cyc++;
          end
          chk($sformatf("v%0d_stall_busy", v), oBusy, 1);
          iEn = 1'b1;
        end
        iBit = vecs[v].bits[i];
        // A stray iStart mid-window must not restart the window.
        iStart = (i == 5);
        tick();
        cyc++;
        if (i < 15) chk($sformatf("v%0d_early_valid", v), oValid, 0);
      end
      iStart = 1'b0;
      chk($sformatf("v%0d_valid", v), oValid, 1);
      chk($sformatf("v%0d_latency", v), cyc, vecs[v].expLat);
      chk($sformatf("v%0d_value", v), oValue, vecs[v].expVal);
      chk($sformatf("v%0d_busy_done", v), oBusy, 0);
      // Hold in DONE without ack; iStart must be ignored.
      iStart = 1'b1;
      for (int h = 0; h < 3; h++) tick();
      iStart = 1'b0;
      chk($sformatf("v%0d_hold_valid", v), oValid, 1);
      chk($sformatf("v%0d_hold_value", v), oValue, vecs[v].expVal);
      iAck = 1'b1;
      tick();
      iAck = 1'b0;
      chk($sformatf("v%0d_ack_valid", v), oValid, 0);
      chk($sformatf("v%0d_ack_busy", v), oBusy, 0);
    end

    // iAck while idle is ignored.
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    chk("idle_ack_busy", oBusy, 0);

    // Reset mid-window: outputs drop without a clock edge, partial window lost.
    iStart = 1'b1;
    tick();
    iStart = 1'b0; iBit = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    #2 iRst = 1'b1;
    #1;
    chk("midrst_busy",  oBusy,  0);
    chk("midrst_valid", oValid, 0);
    chk("midrst_value", oValue, 0);
    @(negedge iClk);
    iRst = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (oValid) sawValid = 1'b1;
    end
    chk("midrst_no_valid", sawValid, 0);
    chk("midrst_idle", oBusy, 0);

    // Clear and start together: stays idle.
    iClr = 1'b1; iStart = 1'b1;
    tick();
    iClr = 1'b0; iStart = 1'b0;
    chk("clr_start_busy", oBusy, 0);

    // Clear in DONE wipes the held result.
    iStart = 1'b1;
    tick();
    iStart = 1'b0; iBit = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    chk("clr_pre_valid", oValid, 1);
    chk("clr_pre_value", oValue, 8);
    iClr = 1'b1; iAck = 1'b1;
    tick();
    iClr = 1'b0; iAck = 1'b0;
    chk("clr_valid", oValid, 0);
    chk("clr_value", oValue, 0);
    chk("clr_busy",  oBusy,  0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/udec_bi.md
UDEC_BI -- requirements
Module: udec_bi

Interface
REQ-001 SHALL provide parameter BITWIDTH, default 8, giving a window length N = 2^BITWIDTH sampled bits (BITWIDTH >= 2).
REQ-002 SHALL provide iClk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide iRst, input, 1, asynchronous active-high reset.
REQ-004 SHALL provide iEn, input, 1, global stall; when 0, all state and outputs hold.
REQ-005 SHALL provide iClr, input, 1, synchronous clear to the post-reset state.
REQ-006 SHALL provide iStart, input, 1, request to begin one decode window.
REQ-007 SHALL provide iBit, input, 1, bipolar stochastic bitstream to decode; bit=1 means +1, bit=0 means -1.
REQ-008 SHALL provide iAck, input, 1, consumer acknowledge of oValue.
REQ-009 SHALL provide oBusy, output, 1, high while in ACC.
REQ-010 SHALL provide oValid, output, 1, high while oValue holds a completed result.
REQ-011 SHALL provide oValue, output, BITWIDTH+1, signed two's-complement decoded value.

Function
REQ-012 SHALL implement states IDLE, ACC and DONE; all transitions occur only in cycles with iEn=1.
REQ-013 In IDLE with iStart=1, SHALL go to ACC and zero the ones counter (BITWIDTH+1 bits) and the sample counter (BITWIDTH bits).
REQ-014 In ACC, each iEn=1 cycle SHALL sample iBit, add it to the ones counter and increment the sample counter.
REQ-015 On the sample at sample counter N-1, SHALL go to DONE and register oValue = ones - 2^(BITWIDTH-1), with this last sample included; the result spans -2^(BITWIDTH-1) to +2^(BITWIDTH-1).
REQ-016 SHALL hold oValid=1 and oValue stable in DONE; DONE with iAck=1 SHALL go to IDLE, dropping oValid the next cycle.
REQ-017 SHALL place the first sample in the cycle after iStart is accepted; with iEn held high, oValid SHALL rise N+1 cycles after iStart.
REQ-018 SHALL ignore iStart in ACC and DONE, and ignore iAck outside DONE.
REQ-019 iEn=0 cycles in ACC SHALL neither sample nor count; the window resumes unchanged.
REQ-020 The sample counter SHALL wrap from N-1 to 0 at window end; the ones counter SHALL never overflow, having maximum value N.
REQ-021 iClr=1 with iEn=1 SHALL have priority over iStart and iAck, forcing IDLE with all counters and outputs zero.

Reset
REQ-022 While iRst=1, SHALL force IDLE, counters 0, oBusy=0, oValid=0 and oValue=0, independent of iClk.
REQ-023 Reset asserted mid-window SHALL discard the partial window; after release, no oValid until a new iStart completes a full window.

Configuration
REQ-024 With macro UDEC_BI_CONTINUOUS_EN defined, SHALL, at window end, register oValue, pulse oValid for exactly one cycle, zero both counters and stay in ACC, so windows run back-to-back with no lost sample; DONE is unreachable and iAck is ignored.
REQ-025 Without UDEC_BI_CONTINUOUS_EN, SHALL behave per REQ-015 to REQ-018 with the hold-until-iAck handshake.

Verification (BITWIDTH=4, N=16, offset 8)
REQ-026 iStart, then 16 ones with iEn=1 -> oValid=1 and oValue=+8 at 17 cycles after iStart; iAck -> oValid=0 next cycle.
REQ-027 iStart, then 16 zeros -> oValue=-8; iStart, then alternating 1/0 -> oValue=0; iStart, then 12 ones and 4 zeros -> oValue=+4.
REQ-028 iStart, 8 samples, iEn=0 for 5 cycles, then 8 more samples (12 ones total) -> oValue=+4, oValid 5 cycles later than with no stall.
REQ-029 iRst pulsed after 10 samples -> outputs 0 immediately and no oValid; iClr and iStart high together -> state stays IDLE.
REQ-030 With UDEC_BI_CONTINUOUS_EN, one iStart and 48 cycles of ones -> three one-cycle oValid pulses 16 cycles apart, each with oValue=+8.
